// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and widths used by the instruction-memory loader
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  // States in which the loader is consuming a frame
  function automatic logic is_loading(input loader_state_t s);
    return (s != IDLE) && (s != DONE) && (s != ERR);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - idle-cycle watchdog for the byte stream while loading
module loader_timeout #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // TIMEOUT of zero never expires; the counter then just free-runs harmlessly
  assign expired = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT));

  // Count idle cycles, holding at the limit once reached
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing instruction memory and gating CPU reset
module imem_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = PC_W,
  parameter int DATA_W  = INSTR_W,
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);

  loader_state_t     state, next_state;
  logic              accept;
  logic              start_load;
  logic              write_word;
  logic              expired;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [15:0]       len_full;
  logic              len_big;
  logic              len_zero;
  logic              last_word;
  logic [7:0]        hi_q;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] addr_cnt;

  assign accept    = byte_valid && byte_ready;
  assign len_full  = {len_hi_q, byte_data};
  assign len_big   = {16'd0, len_full} > 32'(DEPTH);
  assign len_zero  = (len_full == 16'd0);
  assign last_word = (32'(word_count) + 32'd1) == 32'(len_q);

  assign busy     = is_loading(state);
  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign cpu_hold = (state != DONE);

  loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept || !is_loading(state)),
    .en     (is_loading(state)),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus one-cycle control strobes for the datapath
  always_comb begin
    next_state = state;
    start_load = 1'b0;
    write_word = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          next_state = LEN_HI;
          start_load = 1'b1;
        end
      end
      LEN_HI: begin
        if (accept) next_state = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          if (len_big)       next_state = ERR;
          else if (len_zero) next_state = CHECK;
          else               next_state = DATA_HI;
        end
      end
      DATA_HI: begin
        if (accept) next_state = DATA_LO;
      end
      DATA_LO: begin
        if (accept) begin
          write_word = 1'b1;
          next_state = last_word ? CHECK : DATA_HI;
        end
      end
      CHECK: begin
        if (accept) next_state = (byte_data == csum) ? DONE : ERR;
      end
      default: next_state = IDLE;
    endcase
    // A stalled stream aborts the load; a byte arriving this cycle takes priority
    if (is_loading(state) && !accept && expired) begin
      next_state = ERR;
    end
  end

  // Frame datapath: length capture, word assembly, checksum, write port and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      addr_cnt   <= '0;
      len_hi_q   <= '0;
      len_q      <= '0;
      hi_q       <= '0;
      csum       <= '0;
    end else begin
      byte_ready <= is_loading(next_state);
      wr_en      <= write_word;
      if (start_load) begin
        csum       <= '0;
        addr_cnt   <= '0;
        word_count <= '0;
      end
      if (accept && state == LEN_HI) begin
        len_hi_q <= byte_data;
      end
      if (accept && state == LEN_LO) begin
        len_q <= len_full;
      end
      if (accept && state == DATA_HI) begin
        hi_q <= byte_data;
        csum <= csum ^ byte_data;
      end
      if (write_word) begin
        csum     <= csum ^ byte_data;
        wr_data  <= DATA_W'({hi_q, byte_data});
        wr_addr  <= addr_cnt;
        addr_cnt <= addr_cnt + 1'b1;
        if (word_count != ADDR_W'(DEPTH)) begin
          word_count <= word_count + 1'b1;
        end
      end
    end
  end

endmodule
